// File: rtl/dvi_outfmt.sv
// DVI output formatter: pattern source, blanking, sync polarity, SDR/DDR split and line-length monitor.
// Latency: DLY DCLK cycles from DSP_* to DVI_*; LINE_PIX/ERR_LINE update 2 cycles after the input DE fall.
// Backpressure: none, one pixel is accepted on every DCLK cycle.
module dvi_outfmt #(
    parameter int BPC   = 8,
    parameter int DLY   = 2,
    parameter int DDR   = 1,
    parameter int BAR_W = 100,
    localparam int PW   = 3 * BPC,
    localparam int OW   = (DDR != 0) ? PW / 2 : PW
) (
    input  logic            DCLK,
    input  logic            DRST,
    input  logic [1:0]      MODE,
    input  logic [PW-1:0]   SOLID_RGB,
    input  logic            HS_INV,
    input  logic            VS_INV,
    input  logic [BPC-1:0]  DSP_R,
    input  logic [BPC-1:0]  DSP_G,
    input  logic [BPC-1:0]  DSP_B,
    input  logic            DSP_DE,
    input  logic            DSP_HSYNC_X,
    input  logic            DSP_VSYNC_X,
    output logic            DVI_DE,
    output logic            DVI_HSYNC,
    output logic            DVI_VSYNC,
    output logic [OW-1:0]   DVI_D1,
    output logic [OW-1:0]   DVI_D2,
    output logic [15:0]     LINE_PIX,
    input  logic            ERR_CLR,
    output logic            ERR_LINE
);
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] INBAR_MAX = BW'(BAR_W - 1);

    logic [PW-1:0] s1_pix;
    logic          s1_de, s1_hs, s1_vs, s1_de_q, s1_vs_q;
    logic          de_rise, de_fall, vs_fall;

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            s1_pix  <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_de_q <= 1'b0;
            s1_vs_q <= 1'b0;
        end else begin
            s1_pix  <= {DSP_R, DSP_G, DSP_B};
            s1_de   <= DSP_DE;
            s1_hs   <= DSP_HSYNC_X;
            s1_vs   <= DSP_VSYNC_X;
            s1_de_q <= s1_de;
            s1_vs_q <= s1_vs;
        end
    end

    assign de_rise = s1_de & ~s1_de_q;
    assign de_fall = ~s1_de & s1_de_q;
    assign vs_fall = ~s1_vs & s1_vs_q;

    // The first pixel of a line must already see the new mode and cleared bar counters.
    logic [1:0]    am, am_eff;
    logic [BW-1:0] inbar, inbar_eff;
    logic [2:0]    bar, bar_eff;
    logic [PW-1:0] bar_pix, sel_pix;

    always_comb begin
        am_eff    = de_rise ? MODE : am;
        inbar_eff = de_rise ? '0 : inbar;
        bar_eff   = de_rise ? 3'd0 : bar;
        bar_pix   = {{BPC{~bar_eff[1]}}, {BPC{~bar_eff[2]}}, {BPC{~bar_eff[0]}}};
        sel_pix   = '0;
        if (s1_de) begin
            case (am_eff)
                2'd0:    sel_pix = s1_pix;
                2'd1:    sel_pix = bar_pix;
                2'd2:    sel_pix = SOLID_RGB;
                default: sel_pix = '0;
            endcase
        end
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            am    <= 2'd0;
            inbar <= '0;
            bar   <= 3'd0;
        end else begin
            am    <= am_eff;
            inbar <= inbar_eff;
            bar   <= bar_eff;
            if (s1_de) begin
                if (inbar_eff == INBAR_MAX) begin
                    inbar <= '0;
                    bar   <= (bar_eff == 3'd7) ? bar_eff : bar_eff + 3'd1;
                end else begin
                    inbar <= inbar_eff + 1'b1;
                end
            end
        end
    end

    logic [PW-1:0] pix_q [DLY:2];
    logic          de_q  [DLY:2];
    logic          hs_q  [DLY:2];
    logic          vs_q  [DLY:2];

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            for (int k = 2; k <= DLY; k++) begin
                pix_q[k] <= '0;
                de_q[k]  <= 1'b0;
                hs_q[k]  <= 1'b0;
                vs_q[k]  <= 1'b0;
            end
        end else begin
            pix_q[2] <= sel_pix;
            de_q[2]  <= s1_de;
            hs_q[2]  <= s1_hs ^ HS_INV;
            vs_q[2]  <= s1_vs ^ VS_INV;
            for (int k = 3; k <= DLY; k++) begin
                pix_q[k] <= pix_q[k-1];
                de_q[k]  <= de_q[k-1];
                hs_q[k]  <= hs_q[k-1];
                vs_q[k]  <= vs_q[k-1];
            end
        end
    end

    assign DVI_DE    = de_q[DLY];
    assign DVI_HSYNC = hs_q[DLY];
    assign DVI_VSYNC = vs_q[DLY];

    generate
        if (DDR != 0) begin : g_ddr
            assign DVI_D1 = pix_q[DLY][OW-1:0];
            assign DVI_D2 = pix_q[DLY][PW-1:OW];
        end else begin : g_sdr
            assign DVI_D1 = pix_q[DLY];
            assign DVI_D2 = '0;
        end
    endgenerate

    logic [15:0] cnt, ref_len;
    logic        ref_valid, err_set;

    assign err_set = de_fall & ref_valid & (cnt != ref_len);

    // A VSYNC fall overrides the ref_valid set of a coincident DE fall.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            cnt       <= 16'd0;
            ref_len   <= 16'd0;
            ref_valid <= 1'b0;
            LINE_PIX  <= 16'd0;
            ERR_LINE  <= 1'b0;
        end else begin
            if (de_fall) begin
                LINE_PIX <= cnt;
                ref_len  <= cnt;
                cnt      <= 16'd0;
            end else if (s1_de && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (vs_fall)
                ref_valid <= 1'b0;
            else if (de_fall)
                ref_valid <= 1'b1;
            if (err_set)
                ERR_LINE <= 1'b1;
            else if (ERR_CLR)
                ERR_LINE <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dvi_outfmt.sv
// Randomized bench for dvi_outfmt: a line-oriented reference model predicts every output each cycle.
// Inputs change #1 after the rising edge, outputs are sampled on the falling edge.
module tb_dvi_outfmt;
    localparam int BPC = 8, DLY = 2, DDR = 1, BAR_W = 4;
    localparam int PW = 3 * BPC, OW = PW / 2;

    logic            DCLK = 1'b0;
    logic            DRST, HS_INV, VS_INV, ERR_CLR;
    logic [1:0]      MODE;
    logic [PW-1:0]   SOLID_RGB;
    logic [BPC-1:0]  DSP_R, DSP_G, DSP_B;
    logic            DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X;
    logic            DVI_DE, DVI_HSYNC, DVI_VSYNC, ERR_LINE;
    logic [OW-1:0]   DVI_D1, DVI_D2;
    logic [15:0]     LINE_PIX;

    dvi_outfmt #(.BPC(BPC), .DLY(DLY), .DDR(DDR), .BAR_W(BAR_W)) dut (
        .DCLK(DCLK), .DRST(DRST), .MODE(MODE), .SOLID_RGB(SOLID_RGB),
        .HS_INV(HS_INV), .VS_INV(VS_INV),
        .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
        .DSP_DE(DSP_DE), .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X),
        .DVI_DE(DVI_DE), .DVI_HSYNC(DVI_HSYNC), .DVI_VSYNC(DVI_VSYNC),
        .DVI_D1(DVI_D1), .DVI_D2(DVI_D2), .LINE_PIX(LINE_PIX),
        .ERR_CLR(ERR_CLR), .ERR_LINE(ERR_LINE)
    );

    always #5 DCLK = ~DCLK;

    int n_chk = 0, n_err = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Next-cycle input values, applied together just after a rising edge.
    logic          nx_rst, nx_hsinv, nx_vsinv, nx_clr, nx_de, nx_hs, nx_vs;
    logic [1:0]    nx_mode;
    logic [PW-1:0] nx_solid, nx_pix;

    // Per-cycle history (ring) and the expected stage output for each input cycle.
    logic          r_rst [64], r_de [64], r_hs [64], r_vs [64], r_hsinv [64], r_vsinv [64], r_clr [64];
    logic [1:0]    r_mode [64];
    logic [PW-1:0] r_pix [64], r_solid [64], e_pix [64];
    logic          e_de [64], e_hs [64], e_vs [64];

    logic [1:0]  ln_mode;
    int          ln_pos;
    logic [15:0] m_cnt, m_ref, m_lp;
    logic        m_refv, m_err;

    function automatic int ix(input int k);
        return k & 63;
    endfunction

    function automatic logic [PW-1:0] bar_colour(input int pos);
        int b = pos / BAR_W;
        logic [2:0] rgb;
        if (b > 7) b = 7;
        case (b)
            0: rgb = 3'b111;  1: rgb = 3'b110;  2: rgb = 3'b011;  3: rgb = 3'b010;
            4: rgb = 3'b101;  5: rgb = 3'b100;  6: rgb = 3'b001;  default: rgb = 3'b000;
        endcase
        return {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
    endfunction

    // Expected output for the input of the previous cycle; mode/colour/polarity come from the cycle after it.
    task automatic model_pipe();
        int i = ix(cyc - 1), p = ix(cyc - 2), c = ix(cyc);
        logic [PW-1:0] px = '0;
        if (r_de[i]) begin
            if (!r_de[p]) begin
                ln_mode = r_mode[c];
                ln_pos  = 0;
            end
            case (ln_mode)
                2'd0:    px = r_pix[i];
                2'd1:    px = bar_colour(ln_pos);
                2'd2:    px = r_solid[c];
                default: px = '0;
            endcase
            ln_pos++;
        end
        e_pix[i] = px;
        e_de[i]  = r_de[i];
        e_hs[i]  = r_hs[i] ^ r_hsinv[c];
        e_vs[i]  = r_vs[i] ^ r_vsinv[c];
    endtask

    // Line monitor state visible after the next edge.
    task automatic model_mon();
        logic set = 1'b0;
        int i = ix(cyc - 1), p = ix(cyc - 2);
        if (r_rst[ix(cyc)]) begin
            m_cnt = 0; m_ref = 0; m_refv = 0; m_lp = 0; m_err = 0;
        end else begin
            if (!r_rst[i]) begin
                if (r_de[p] && !r_de[i]) begin
                    m_lp   = m_cnt;
                    set    = m_refv && (m_cnt != m_ref);
                    m_ref  = m_cnt;
                    m_refv = 1'b1;
                    m_cnt  = 0;
                end
                if (r_vs[p] && !r_vs[i]) m_refv = 1'b0;
                if (r_de[i] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (set) m_err = 1'b1;
            else if (r_clr[ix(cyc)]) m_err = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        logic skip = 1'b0;
        int e = ix(cyc - DLY);
        for (int d = 2; d <= DLY; d++)
            if (r_rst[ix(cyc - d)]) skip = 1'b1;
        if (r_rst[ix(cyc - 1)]) begin
            check("rst_de", 32'(DVI_DE), 32'd0);
            check("rst_hs", 32'(DVI_HSYNC), 32'd0);
            check("rst_vs", 32'(DVI_VSYNC), 32'd0);
            check("rst_d1", 32'(DVI_D1), 32'd0);
            check("rst_d2", 32'(DVI_D2), 32'd0);
        end else if (!skip) begin
            check("de", 32'(DVI_DE), 32'(e_de[e]));
            check("hs", 32'(DVI_HSYNC), 32'(e_hs[e]));
            check("vs", 32'(DVI_VSYNC), 32'(e_vs[e]));
            check("d1", 32'(DVI_D1), 32'(e_pix[e][OW-1:0]));
            check("d2", 32'(DVI_D2), 32'(e_pix[e][PW-1:OW]));
        end
        check("line_pix", 32'(LINE_PIX), 32'(m_lp));
        check("err_line", 32'(ERR_LINE), 32'(m_err));
    endtask

    task automatic step();
        int k;
        @(posedge DCLK);
        #1;
        cyc++;
        k = ix(cyc);
        DRST = nx_rst;  MODE = nx_mode;  SOLID_RGB = nx_solid;
        HS_INV = nx_hsinv;  VS_INV = nx_vsinv;  ERR_CLR = nx_clr;
        DSP_R = nx_pix[23:16];  DSP_G = nx_pix[15:8];  DSP_B = nx_pix[7:0];
        DSP_DE = nx_de;  DSP_HSYNC_X = nx_hs;  DSP_VSYNC_X = nx_vs;
        r_rst[k] = nx_rst;  r_mode[k] = nx_mode;  r_solid[k] = nx_solid;
        r_hsinv[k] = nx_hsinv;  r_vsinv[k] = nx_vsinv;  r_clr[k] = nx_clr;
        r_pix[k] = nx_pix;
        r_de[k] = nx_rst ? 1'b0 : nx_de;
        r_hs[k] = nx_rst ? 1'b0 : nx_hs;
        r_vs[k] = nx_rst ? 1'b0 : nx_vs;
        model_pipe();
        @(negedge DCLK);
        if (cyc >= 2) compare_outputs();
        model_mon();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            nx_de  = 1'b0;
            nx_pix = PW'($urandom);
            step();
        end
    endtask

    task automatic line(input int len, input int gap);
        for (int p = 0; p < len; p++) begin
            nx_de  = 1'b1;
            nx_pix = PW'($urandom);
            step();
        end
        idle(gap);
    endtask

    initial begin
        int len, sw, prev_len;
        for (int k = 0; k < 64; k++) begin
            r_rst[k] = 1'b1; r_de[k] = 1'b0; r_hs[k] = 1'b0; r_vs[k] = 1'b0;
            r_hsinv[k] = 1'b0; r_vsinv[k] = 1'b0; r_clr[k] = 1'b0; r_mode[k] = 2'd0;
            r_pix[k] = '0; r_solid[k] = '0; e_pix[k] = '0; e_de[k] = 1'b0; e_hs[k] = 1'b0; e_vs[k] = 1'b0;
        end
        ln_mode = 2'd0; ln_pos = 0;
        m_cnt = 0; m_ref = 0; m_lp = 0; m_refv = 0; m_err = 0;
        nx_rst = 1'b1; nx_mode = 2'd0; nx_solid = '0; nx_hsinv = 1'b0; nx_vsinv = 1'b0;
        nx_clr = 1'b0; nx_de = 1'b0; nx_pix = '0; nx_hs = 1'b1; nx_vs = 1'b1;
        DRST = 1'b1; MODE = 2'd0; SOLID_RGB = '0; HS_INV = 1'b0; VS_INV = 1'b0; ERR_CLR = 1'b0;
        DSP_R = '0; DSP_G = '0; DSP_B = '0; DSP_DE = 1'b0; DSP_HSYNC_X = 1'b1; DSP_VSYNC_X = 1'b1;

        repeat (4) step();
        nx_rst = 1'b0;
        idle(4);

        // Pass-through of a known pixel, then the same data blanked.
        nx_de = 1'b1; nx_pix = 24'hABCDEF;
        repeat (3) step();
        check("pt_d1", 32'(DVI_D1), 32'h0DEF);
        check("pt_d2", 32'(DVI_D2), 32'h0ABC);
        check("pt_de", 32'(DVI_DE), 32'd1);
        nx_de = 1'b0;
        repeat (3) step();
        check("blank_d1", 32'(DVI_D1), 32'd0);
        check("blank_d2", 32'(DVI_D2), 32'd0);
        idle(3);

        // Mode switch to solid colour mid-line takes effect on the next line.
        nx_solid = 24'h123456;
        for (int p = 0; p < 30; p++) begin
            if (p == 10) nx_mode = 2'd2;
            nx_de = 1'b1; nx_pix = PW'($urandom);
            step();
        end
        idle(6);
        line(30, 6);

        // Colour bars over a 40-pixel line.
        nx_mode = 2'd1;
        line(40, 8);

        // Inverted HSYNC, VSYNC untouched.
        nx_mode = 2'd0; nx_hsinv = 1'b1;
        idle(3);
        nx_hs = 1'b0;
        idle(128);
        check("hs_inv_high", 32'(DVI_HSYNC), 32'd1);
        check("vs_plain", 32'(DVI_VSYNC), 32'd1);
        nx_hs = 1'b1;
        idle(3);
        check("hs_inv_low", 32'(DVI_HSYNC), 32'd0);
        nx_hsinv = 1'b0;

        // Randomized lines: modes, mid-line switches, polarity, vsync falls, error clears.
        prev_len = 20;
        for (int l = 0; l < 60; l++) begin
            nx_mode  = 2'($urandom_range(0, 3));
            nx_solid = PW'($urandom);
            if ($urandom_range(0, 3) == 0) nx_hsinv = ~nx_hsinv;
            if ($urandom_range(0, 3) == 0) nx_vsinv = ~nx_vsinv;
            len = ($urandom_range(0, 1) == 1) ? prev_len : $urandom_range(1, 60);
            prev_len = len;
            sw = $urandom_range(0, len);
            for (int p = 0; p < len; p++) begin
                if (p == sw) nx_mode = 2'($urandom_range(0, 3));
                nx_de = 1'b1; nx_pix = PW'($urandom);
                step();
            end
            nx_vs = ($urandom_range(0, 5) != 0);
            nx_hs = 1'b0;
            repeat ($urandom_range(1, 8)) begin
                nx_clr = ($urandom_range(0, 4) == 0);
                nx_de = 1'b0; nx_pix = PW'($urandom);
                step();
                nx_vs = 1'b1; nx_hs = 1'b1;
            end
            nx_clr = 1'b0;
        end
        nx_mode = 2'd0; nx_hsinv = 1'b0; nx_vsinv = 1'b0;
        idle(4);

        // Line-length monitor over a frame.
        nx_vs = 1'b0; idle(3); nx_vs = 1'b1; idle(3);
        line(800, 10);
        line(800, 10);
        line(799, 10);
        check("mon_lp_799", 32'(LINE_PIX), 32'd799);
        check("mon_err_set", 32'(ERR_LINE), 32'd1);
        nx_clr = 1'b1; idle(1); nx_clr = 1'b0; idle(2);
        check("mon_err_clr", 32'(ERR_LINE), 32'd0);
        line(800, 0);
        nx_de = 1'b0; step();
        nx_clr = 1'b1; step();
        nx_clr = 1'b0; idle(4);
        check("mon_set_wins", 32'(ERR_LINE), 32'd1);
        nx_clr = 1'b1; idle(1); nx_clr = 1'b0; idle(2);
        check("mon_err_clr2", 32'(ERR_LINE), 32'd0);
        nx_vs = 1'b0; idle(3); nx_vs = 1'b1; idle(3);
        line(640, 10);
        check("mon_first_line", 32'(ERR_LINE), 32'd0);
        check("mon_lp_640", 32'(LINE_PIX), 32'd640);

        // VSYNC falling with DE: compare against the old reference, then restart the frame.
        line(500, 0);
        nx_vs = 1'b0; idle(1); nx_vs = 1'b1; idle(5);
        check("vs_de_cmp", 32'(ERR_LINE), 32'd1);
        nx_clr = 1'b1; idle(1); nx_clr = 1'b0; idle(2);
        line(300, 5);
        check("vs_de_noref", 32'(ERR_LINE), 32'd0);

        // Reset in the middle of a line with inverted syncs.
        line(50, 5);
        check("pre_rst_err", 32'(ERR_LINE), 32'd1);
        nx_hsinv = 1'b1; nx_vsinv = 1'b1;
        line(8, 0);
        nx_rst = 1'b1; nx_de = 1'b0; step();
        nx_rst = 1'b0; step();
        check("rst_mid_hs", 32'(DVI_HSYNC), 32'd0);
        check("rst_mid_vs", 32'(DVI_VSYNC), 32'd0);
        check("rst_mid_err", 32'(ERR_LINE), 32'd0);
        idle(5);
        line(16, 5);
        check("post_rst_lp", 32'(LINE_PIX), 32'd16);
        check("post_rst_err", 32'(ERR_LINE), 32'd0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
